// File: rtl/tanh4_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin tanh4 scheduler.
// Holds the 4-bit approximate tanh core and the round-robin search.
package tanh4_rr_scheduler_pkg;

  localparam int TANH4_W = 4;
  localparam int MAXREQ  = 8;

  function automatic logic [TANH4_W-1:0] core(
    input logic [TANH4_W-1:0] x
  );
    logic [TANH4_W-1:0] y;
    y[0] = x[0];
    y[1] = x[0];
    y[2] = ((x[0] ^ x[1]) | x[2]) & x[1];
    y[3] = ~(x[1] ^ (x[3] | (x[0] ^ x[1])));
    return y;
  endfunction

  // First set bit of vec at or after ptr, wrapping mod n.
  // Returns ptr when vec has no set bit below n.
  function automatic logic [2:0] find_first_from(
    input logic [2:0]        ptr,
    input logic [MAXREQ-1:0] vec,
    input int                n
  );
    logic [2:0] w;
    logic       hit;
    int         idx;
    w   = ptr;
    hit = 1'b0;
    for (int k = 0; k < MAXREQ; k++) begin
      idx = (int'(ptr) + k) % n;
      if (!hit && k < n && vec[idx[2:0]]) begin
        w   = 3'(idx);
        hit = 1'b1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/tanh4_rr_scheduler_arb.sv
// Round-robin arbiter: combinational winner, registered pointer.
// Ports: req_valid in, accept in (handshake taken), winner/any out.
module tanh4_rr_scheduler_arb
  import tanh4_rr_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_valid,
  input  logic            accept,
  output logic [IDW-1:0]  winner,
  output logic            any
);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] nxt_ptr;

  assign any = |req_valid;

  assign winner = IDW'(find_first_from(
    3'(rr_ptr), MAXREQ'(req_valid), NREQ));

  assign nxt_ptr = (winner == IDW'(NREQ - 1))
                 ? '0
                 : winner + IDW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= nxt_ptr;
    end
  end

endmodule

// File: rtl/tanh4_rr_scheduler.sv
// Shares one tanh4 core among NREQ requesters, two-stage pipeline.
// Ports: req_valid/req_data/req_ready in, rsp_* out, busy out.
module tanh4_rr_scheduler
  import tanh4_rr_scheduler_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [TANH4_W*NREQ-1:0] req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [TANH4_W-1:0]      rsp_data,
  output logic [IDW-1:0]          rsp_id,
  output logic                    busy
);

  logic               a_vld;
  logic [TANH4_W-1:0] a_x;
  logic [IDW-1:0]     a_id;
  logic               b_vld;
  logic [TANH4_W-1:0] b_y;
  logic [IDW-1:0]     b_id;

  logic               a_load;
  logic               b_load;
  logic               accept;
  logic               any;
  logic [IDW-1:0]     winner;
  logic [TANH4_W-1:0] sel_x;

  tanh4_rr_scheduler_arb #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .accept   (accept),
    .winner   (winner),
    .any      (any)
  );

  assign b_load = a_vld & (~b_vld | rsp_ready);
  assign a_load = ~a_vld | b_load;
  // rst_n gate keeps req_ready low while reset is held
  assign accept = rst_n & a_load & any;

  assign sel_x = req_data[int'(winner)*TANH4_W +: TANH4_W];

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept & (winner == IDW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld <= 1'b0;
      a_x   <= '0;
      a_id  <= '0;
      b_vld <= 1'b0;
      b_y   <= '0;
      b_id  <= '0;
    end else begin
      if (b_load) begin
        b_vld <= 1'b1;
        b_y   <= core(a_x);
        b_id  <= a_id;
      end else if (rsp_ready) begin
        b_vld <= 1'b0;
      end
      if (a_load) begin
        a_vld <= any;
        if (any) begin
          a_x  <= sel_x;
          a_id <= winner;
        end
      end
    end
  end

  assign rsp_valid = b_vld;
  assign rsp_data  = b_y;
  assign rsp_id    = b_id;
  assign busy      = a_vld | b_vld;

endmodule

// File: tb/tb_tanh4_rr_scheduler.sv
// Scoreboard bench for tanh4_rr_scheduler with directed vectors.
// Stimulus pushes expected results; a monitor pops on rsp handshake.
module tb_tanh4_rr_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;

  int n_cmp;
  int n_bad;

  logic [7:0]  sb[$];
  // hand-computed core(x), nibble x holds core(x)
  logic [63:0] tbl;

  tanh4_rr_scheduler #(
    .NREQ(4),
    .IDW (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_id   (rsp_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(
    input logic [3:0]  v,
    input logic [15:0] d,
    input logic        rr
  );
    logic [3:0] x;
    @(posedge clk);
    #1;
    req_valid = v;
    req_data  = d;
    rsp_ready = rr;
    #2;
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        x = req_data[i*4 +: 4];
        sb.push_back({4'(i), tbl[int'(x)*4 +: 4]});
      end
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n && rsp_valid && rsp_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_unexpected: got id %0d data %0h want none",
                 rsp_id, rsp_data);
      end else begin
        e = sb.pop_front();
        if ({2'b00, rsp_id, rsp_data} !== e) begin
          n_bad++;
          $display("FAIL rsp: got id %0d data %0h want id %0d data %0h",
                   rsp_id, rsp_data, e[7:4], e[3:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl       = 64'hFC30BC307C383C38;
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;
    rsp_ready = 1'b1;
    #3;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst_n     = 1'b1;

    // single request from requester 2, x=0101
    step(4'b0100, 16'h0500, 1'b1);
    chk("single_ready", 32'(req_ready), 32'b0100);
    step(4'b0000, 16'h0000, 1'b1);
    chk("single_lat1_valid", 32'(rsp_valid), 0);
    chk("single_lat1_busy", 32'(busy), 1);
    step(4'b0000, 16'h0000, 1'b1);
    chk("single_lat2_valid", 32'(rsp_valid), 1);
    chk("single_data", 32'(rsp_data), 32'h3);
    chk("single_id", 32'(rsp_id), 2);

    // all 16 core inputs through requester 0, back to back
    for (int i = 0; i < 16; i++) begin
      step(4'b0001, {12'h000, 4'(i)}, 1'b1);
      chk("core_ready", 32'(req_ready), 32'b0001);
    end
    step(4'b0000, 16'h0000, 1'b1);

    // steer pointer to 0 via requester 3
    step(4'b1000, 16'hB000, 1'b1);
    chk("ptr_ready3", 32'(req_ready), 32'b1000);

    // fairness: everyone valid
    for (int k = 0; k < 8; k++) begin
      step(4'b1111, 16'hFA51, 1'b1);
      chk("fair_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
    end
    for (int k = 0; k < 3; k++) step(4'b0000, 16'h0000, 1'b1);

    // backpressure with requesters 1 and 3
    step(4'b1010, 16'hB070, 1'b0);
    chk("bp_ready1", 32'(req_ready), 32'b0010);
    step(4'b1010, 16'hB070, 1'b0);
    chk("bp_ready3", 32'(req_ready), 32'b1000);
    step(4'b1010, 16'hB070, 1'b0);
    chk("bp_full_ready", 32'(req_ready), 0);
    chk("bp_valid", 32'(rsp_valid), 1);
    chk("bp_id", 32'(rsp_id), 1);
    chk("bp_data", 32'(rsp_data), 32'h7);
    step(4'b1010, 16'hB070, 1'b0);
    chk("bp_hold_ready", 32'(req_ready), 0);
    chk("bp_hold_id", 32'(rsp_id), 1);
    chk("bp_hold_data", 32'(rsp_data), 32'h7);
    chk("bp_busy", 32'(busy), 1);
    step(4'b1010, 16'hB070, 1'b1);
    chk("bp_resume_ready", 32'(req_ready), 32'b0010);
    for (int k = 0; k < 3; k++) step(4'b0000, 16'h0000, 1'b1);

    // pointer wrap: move pointer to 3, then 0 and 3 compete
    step(4'b0100, 16'h0300, 1'b1);
    chk("wrap_pre", 32'(req_ready), 32'b0100);
    step(4'b1001, 16'hD00E, 1'b1);
    chk("wrap_first", 32'(req_ready), 32'b1000);
    step(4'b1001, 16'hD00E, 1'b1);
    chk("wrap_second", 32'(req_ready), 32'b0001);
    for (int k = 0; k < 3; k++) step(4'b0000, 16'h0000, 1'b1);

    // reset with both stages full, pointer left at 3
    step(4'b0100, 16'h0900, 1'b0);
    chk("mid_acc1", 32'(req_ready), 32'b0100);
    step(4'b0100, 16'h0900, 1'b0);
    chk("mid_acc2", 32'(req_ready), 32'b0100);
    step(4'b0000, 16'h0000, 1'b0);
    chk("mid_busy", 32'(busy), 1);
    chk("mid_valid", 32'(rsp_valid), 1);
    #1;
    rst_n     = 1'b0;
    req_valid = 4'b1100;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    sb.delete();
    @(posedge clk);
    #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b1;
    #1;
    chk("post_rst_valid", 32'(rsp_valid), 0);
    chk("post_rst_busy", 32'(busy), 0);
    step(4'b1100, 16'h6900, 1'b1);
    chk("post_rst_ptr", 32'(req_ready), 32'b0100);
    for (int k = 0; k < 4; k++) step(4'b0000, 16'h0000, 1'b1);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tanh4_rr_scheduler.md
# tanh4_rr_scheduler

Round-robin scheduler that shares a single combinational 4-bit approximate tanh core between `NREQ` requesters. Each requester has its own valid/ready handshake. Accepted operands pass through a two-stage registered pipeline (operand register, then result register). Results are returned on one response port tagged with the requester index. It sits between the per-lane activation requesters of a small 4-bit neural datapath and the shared approximate tanh circuit.

## Interface

- `NREQ`, 4, number of requesters (2..8).
- `IDW`, 2, width of requester tag; must satisfy 2^IDW >= NREQ.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  NREQ  per-requester operand valid.
- `req_data`  in  4*NREQ  operands; requester i uses bits [4i+3:4i].
- `req_ready`  out  NREQ  one-hot-or-zero accept strobe.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  downstream accepts result.
- `rsp_data`  out  4  approximate tanh of the accepted operand.
- `rsp_id`  out  IDW  index of the requester that supplied the operand.
- `busy`  out  1  high while either pipeline stage holds data.

## Operation

- Stage A registers: `a_vld`, `a_x[3:0]`, `a_id`.
- Stage B registers: `b_vld`, `b_y[3:0]`, `b_id`.
- Outputs are driven directly from stage B: `rsp_valid=b_vld`, `rsp_data=b_y`, `rsp_id=b_id`.
- `busy = a_vld | b_vld`.
- Stage B advance: `b_load = a_vld & (~b_vld | rsp_ready)`.
  - When `b_load` is high: `b_y <= core(a_x)`, `b_id <= a_id`, `b_vld <= 1`.
  - Else, when `rsp_ready` is high: `b_vld <= 0`.
- Stage A advance: `a_load = ~a_vld | b_load`.
  - Accept when `a_load` is high and any `req_valid` is high: `a_vld <= 1`, latch the granted operand and index.
  - When `a_load` is high and no request is present: `a_vld <= 0`.
- Arbitration is round-robin with pointer `rr_ptr` (range 0..NREQ-1).
  - The winner is the first set `req_valid` bit searching `rr_ptr`, `rr_ptr+1`, … with wrap mod NREQ.
  - `req_ready[i] = a_load & (winner==i)`.
  - `req_ready` depends combinationally on `req_valid` and `rsp_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- Pointer update: on every accepted handshake, `rr_ptr <= (winner+1) mod NREQ`. With no acceptance, `rr_ptr` holds.
- Core function `core(x)`, with y = result bits:
  - `y0 = y1 = x0`
  - `y2 = ((x0^x1)|x2) & x1`
  - `y3 = ~(x1 ^ (x3|(x0^x1)))`
- A requester holding `req_valid` without `req_ready` keeps its data stable. The scheduler never reorders results: results leave in acceptance order.
- Reset (asynchronous assert, synchronous release) sets all stage registers to 0, `rr_ptr=0`, `rsp_valid=0`, `busy=0`. `req_ready` is 0 only while `rst_n` is low.
- Reset mid-operation discards both stages. No response is emitted for operands accepted before reset.

## Timing

- Latency: an operand accepted at rising edge N (handshake visible in cycle N-1) appears on `rsp_*` in the cycle after edge N+1. That is 2 edges from handshake to `rsp_valid`.
- Throughput: one result per cycle while `rsp_ready=1` and requests are present. No bubbles.
- Backpressure: with `rsp_ready=0`, stage B holds. Stage A fills once more, then `req_ready=0` for all requesters.
  - Max in flight: 2.
- When `rsp_ready` rises and requests are waiting:
  - On the same edge, B takes A's operand and A takes a new operand.
- Starvation bound: a continuously valid requester is granted within NREQ accepts.
- Simultaneous drain and fill in the same cycle is legal and required.

## Structure

- Shared package/header holds:
  - `TANH4_W=4`
  - the `core()` function, or the instantiation of the existing combinational 4-bit approximate tanh core module (`In[3:0]` → `Out1[3:0]`) as the single sub-module
  - a round-robin `find_first_from(ptr, vec)` helper.
- Arbitration, pipeline control and registers live in this module. Target 150–250 lines.

## Test plan

- Reset then single request: requester 2 sends `x=4'b0101` → `req_ready[2]` high that cycle; 2 edges later `rsp_valid=1`, `rsp_data=4'b0011`, `rsp_id=2`.
- Core values: x=`0000`→`1000`, `0010`→`1100`, `1111`→`1111`, `0101`→`0011`, across all 16 inputs via requester 0 → all match the `core()` equations.
- Fairness: all 4 requesters valid continuously, `rsp_ready=1` → grants 0,1,2,3,0,1,… and `rsp_id` follows the same order at one result per cycle.
- Backpressure: `rsp_ready=0` with requesters 1 and 3 valid → exactly 2 accepts (ids 1, 3), then `req_ready=0`. `rsp_data`/`rsp_id` stay stable. After `rsp_ready=1`, results drain in order 1,3 and accepts resume.
- Wrap pointer: `rr_ptr=3` with only requesters 0 and 3 valid → 3 wins, then 0.
- Reset mid-flight: assert `rst_n=0` with both stages full → `rsp_valid`, `busy` and `rr_ptr` go to 0 immediately. No stale response after release.
